// File: rtl/audio_filter_pkg.sv
// Shared definitions for the audio biquad cascade.
//   coef_sel_e  - coefficient slot select (b0, b1, b2, a1, a2)
//   state_e     - sequencer states of the cascade
//   COEF_ONE / ROUND_CONST - unity gain and rounding constants for the
//                  default Q2.14 coefficient format
//   sat_to_width - clamps a signed value to a signed range of a given width
package audio_filter_pkg;

    localparam int DEF_COEF_FRAC = 14;
    localparam int COEF_ONE      = 1 << DEF_COEF_FRAC;
    localparam int ROUND_CONST   = 1 << (DEF_COEF_FRAC - 1);

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Clamp v to [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int unsigned     w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/audio_biquad_cascade_mac.sv
// biquad_mac_unit: the single shared multiply-accumulator of the cascade.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   mac_en                 - accumulate this cycle
//   mac_clr                - start a new sum from the rounding constant
//   mac_sub                - subtract the product instead of adding it
//   mac_data, mac_coef     - signed multiplier operands
//   mac_y                  - (acc >>> COEF_FRAC) saturated to SAMPLE_W
//   sat_flag               - mac_y was clamped
module biquad_mac_unit
    import audio_filter_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = DEF_COEF_FRAC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mac_en,
    input  logic                       mac_clr,
    input  logic                       mac_sub,
    input  logic signed [SAMPLE_W-1:0] mac_data,
    input  logic signed [COEF_W-1:0]   mac_coef,
    output logic signed [SAMPLE_W-1:0] mac_y,
    output logic                       sat_flag
);

    // Three guard bits cover five full-scale products plus rounding.
    localparam int ACC_W  = SAMPLE_W + COEF_W + 3;
    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam logic signed [ACC_W-1:0] ROUND_W = ACC_W'(1) <<< (COEF_FRAC - 1);

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [PROD_W-1:0] product;
    logic signed [63:0]       sat_in;
    logic signed [63:0]       sat_out;

    always_comb begin
        product  = mac_data * mac_coef;
        prod_ext = ACC_W'(product);
        acc_base = mac_clr ? ROUND_W : acc_q;
        acc_d    = acc_q;
        if (mac_en) begin
            acc_d = mac_sub ? (acc_base - prod_ext) : (acc_base + prod_ext);
        end
        shifted  = acc_q >>> COEF_FRAC;
        sat_in   = 64'(shifted);
        sat_out  = sat_to_width(sat_in, SAMPLE_W);
        mac_y    = sat_out[SAMPLE_W-1:0];
        sat_flag = (sat_out != sat_in);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/audio_biquad_cascade.sv
// audio_biquad_cascade: NUM_STAGES direct-form-I biquads run one after the
// other on a single time-multiplexed MAC (5 MAC cycles + 1 writeback per stage).
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   sample_valid      - strobe, adc_data valid (top SAMPLE_W bits used)
//   dac_data          - {8'h00, y, zero pad to 24 bits}
//   out_valid         - strobe, dac_data just updated
//   busy, overrun     - sample in flight / sample dropped because busy
//   coef_we/stage/sel/wdata - write one shadow coefficient
//   coef_commit       - copy shadow bank to active bank at next sample start
//   dbg_state         - current sequencer state
// Optional build macro AUDIO_BIQUAD_CLIP_COUNT_EN adds clip_clear/clip_count.
//
// Handshake: a sample is accepted only when sample_valid is high while busy is
// low. busy rises the cycle after acceptance and falls after the out_valid
// cycle. A sample_valid seen while busy is discarded and overrun pulses the
// following cycle; the running computation is not affected.
module audio_biquad_cascade
    import audio_filter_pkg::*;
#(
    parameter int ADC_W      = 24,
    parameter int SAMPLE_W   = 16,
    parameter int COEF_W     = 16,
    parameter int COEF_FRAC  = DEF_COEF_FRAC,
    parameter int NUM_STAGES = 4,
    localparam int STAGE_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [ADC_W-1:0]   adc_data,
    output logic [31:0]        dac_data,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun,
`ifdef AUDIO_BIQUAD_CLIP_COUNT_EN
    input  logic               clip_clear,
    output logic [15:0]        clip_count,
`endif
    input  logic               coef_we,
    input  logic [STAGE_W-1:0] coef_stage,
    input  logic [2:0]         coef_sel,
    input  logic [COEF_W-1:0]  coef_wdata,
    input  logic               coef_commit,
    output state_e             dbg_state
);

    localparam logic [COEF_W-1:0] COEF_ONE_W = COEF_W'(1 << COEF_FRAC);

    state_e                      state_q, state_d;
    logic [STAGE_W-1:0]          stage_q, stage_d;
    logic [2:0]                  k_q, k_d;
    logic signed [SAMPLE_W-1:0]  cur_x_q, cur_x_d;
    logic signed [SAMPLE_W-1:0]  x1_q [NUM_STAGES];
    logic signed [SAMPLE_W-1:0]  x1_d [NUM_STAGES];
    logic signed [SAMPLE_W-1:0]  x2_q [NUM_STAGES];
    logic signed [SAMPLE_W-1:0]  x2_d [NUM_STAGES];
    logic signed [SAMPLE_W-1:0]  y1_q [NUM_STAGES];
    logic signed [SAMPLE_W-1:0]  y1_d [NUM_STAGES];
    logic signed [SAMPLE_W-1:0]  y2_q [NUM_STAGES];
    logic signed [SAMPLE_W-1:0]  y2_d [NUM_STAGES];
    logic signed [COEF_W-1:0]    shadow_q [NUM_STAGES][5];
    logic signed [COEF_W-1:0]    shadow_d [NUM_STAGES][5];
    logic signed [COEF_W-1:0]    active_q [NUM_STAGES][5];
    logic signed [COEF_W-1:0]    active_d [NUM_STAGES][5];
    logic                        commit_pending_q, commit_pending_d;
    logic [31:0]                 dac_data_q, dac_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        busy_q, busy_d;
    logic                        overrun_q, overrun_d;
    logic                        accept;

    logic                        mac_en, mac_clr, mac_sub, sat_flag;
    logic signed [SAMPLE_W-1:0]  mac_data, mac_y;
    logic signed [COEF_W-1:0]    mac_coef;

    logic                        unused_adc_lsbs;
    assign unused_adc_lsbs = ^adc_data[ADC_W-SAMPLE_W-1:0];

    // Operand select for the five MAC steps of the current stage.
    always_comb begin
        mac_en   = (state_q == ST_MAC);
        mac_clr  = (k_q == 3'd0);
        mac_sub  = (k_q >= 3'd3);
        mac_data = cur_x_q;
        mac_coef = active_q[stage_q][B0];
        case (k_q)
            3'd1: begin
                mac_data = x1_q[stage_q];
                mac_coef = active_q[stage_q][B1];
            end
            3'd2: begin
                mac_data = x2_q[stage_q];
                mac_coef = active_q[stage_q][B2];
            end
            3'd3: begin
                mac_data = y1_q[stage_q];
                mac_coef = active_q[stage_q][A1];
            end
            3'd4: begin
                mac_data = y2_q[stage_q];
                mac_coef = active_q[stage_q][A2];
            end
            default: ;
        endcase
    end

    biquad_mac_unit #(
        .SAMPLE_W (SAMPLE_W),
        .COEF_W   (COEF_W),
        .COEF_FRAC(COEF_FRAC)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .mac_en  (mac_en),
        .mac_clr (mac_clr),
        .mac_sub (mac_sub),
        .mac_data(mac_data),
        .mac_coef(mac_coef),
        .mac_y   (mac_y),
        .sat_flag(sat_flag)
    );

    always_comb begin
        state_d          = state_q;
        stage_d          = stage_q;
        k_d              = k_q;
        cur_x_d          = cur_x_q;
        x1_d             = x1_q;
        x2_d             = x2_q;
        y1_d             = y1_q;
        y2_d             = y2_q;
        shadow_d         = shadow_q;
        active_d         = active_q;
        commit_pending_d = commit_pending_q;
        dac_data_d       = dac_data_q;
        out_valid_d      = 1'b0;
        accept           = sample_valid && (state_q == ST_IDLE) && !busy_q;
        overrun_d        = sample_valid && !accept;

        // Shadow write comes first so a same-cycle commit includes it.
        if (coef_we && (coef_sel <= 3'(A2)) && (int'(coef_stage) < NUM_STAGES)) begin
            shadow_d[coef_stage][coef_sel] = coef_wdata;
        end
        if (coef_commit) begin
            commit_pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_x_d = adc_data[ADC_W-1 -: SAMPLE_W];
                    // Bank swap only here, so one sample never sees mixed sets.
                    if (commit_pending_q || coef_commit) begin
                        active_d         = shadow_d;
                        commit_pending_d = 1'b0;
                    end
                    stage_d = '0;
                    k_d     = 3'd0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (k_q == 3'd4) begin
                    k_d     = 3'd0;
                    state_d = ST_WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_WB: begin
                x2_d[stage_q] = x1_q[stage_q];
                x1_d[stage_q] = cur_x_q;
                y2_d[stage_q] = y1_q[stage_q];
                y1_d[stage_q] = mac_y;
                cur_x_d       = mac_y;
                if (int'(stage_q) == NUM_STAGES - 1) begin
                    state_d = ST_OUT;
                end else begin
                    stage_d = stage_q + 1'b1;
                    state_d = ST_MAC;
                end
            end
            ST_OUT: begin
                dac_data_d  = {8'h00, cur_x_q, {(24 - SAMPLE_W){1'b0}}};
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // busy also covers the out_valid cycle that follows OUT.
        busy_d = (state_d != ST_IDLE) || (state_q == ST_OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            stage_q          <= '0;
            k_q              <= 3'd0;
            cur_x_q          <= '0;
            commit_pending_q <= 1'b0;
            dac_data_q       <= '0;
            out_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
            overrun_q        <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
                for (int c = 0; c < 5; c++) begin
                    shadow_q[s][c] <= (c == 0) ? COEF_ONE_W : '0;
                    active_q[s][c] <= (c == 0) ? COEF_ONE_W : '0;
                end
            end
        end else begin
            state_q          <= state_d;
            stage_q          <= stage_d;
            k_q              <= k_d;
            cur_x_q          <= cur_x_d;
            commit_pending_q <= commit_pending_d;
            dac_data_q       <= dac_data_d;
            out_valid_q      <= out_valid_d;
            busy_q           <= busy_d;
            overrun_q        <= overrun_d;
            x1_q             <= x1_d;
            x2_q             <= x2_d;
            y1_q             <= y1_d;
            y2_q             <= y2_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
        end
    end

`ifdef AUDIO_BIQUAD_CLIP_COUNT_EN
    logic [15:0] clip_count_q, clip_count_d;

    always_comb begin
        clip_count_d = clip_count_q;
        if (clip_clear) begin
            clip_count_d = '0;
        end else if ((state_q == ST_WB) && sat_flag && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign clip_count = clip_count_q;
`endif

    assign dac_data  = dac_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_audio_biquad_cascade.sv
// Self-checking bench for audio_biquad_cascade (default parameters).
module tb_audio_biquad_cascade;
    import audio_filter_pkg::*;

    localparam int NS  = 4;
    localparam int LAT = 6 * NS + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [23:0] adc_data = '0;
    logic [31:0] dac_data;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_stage = '0;
    logic [2:0]  coef_sel = '0;
    logic [15:0] coef_wdata = '0;
    logic        coef_commit = 1'b0;
    state_e      dbg_state;
`ifdef AUDIO_BIQUAD_CLIP_COUNT_EN
    logic        clip_clear = 1'b0;
    logic [15:0] clip_count;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    // Reference model state.
    longint      m_sh [NS][5];
    longint      m_ac [NS][5];
    longint      m_x1 [NS];
    longint      m_x2 [NS];
    longint      m_y1 [NS];
    longint      m_y2 [NS];
    bit          m_pend;
    int          m_clip;

    audio_biquad_cascade dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .adc_data    (adc_data),
        .dac_data    (dac_data),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun),
`ifdef AUDIO_BIQUAD_CLIP_COUNT_EN
        .clip_clear  (clip_clear),
        .clip_count  (clip_count),
`endif
        .coef_we     (coef_we),
        .coef_stage  (coef_stage),
        .coef_sel    (coef_sel),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic m_reset();
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < 5; c++) begin
                m_sh[s][c] = (c == 0) ? 64'sd16384 : 64'sd0;
                m_ac[s][c] = (c == 0) ? 64'sd16384 : 64'sd0;
            end
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_pend = 1'b0;
        m_clip = 0;
    endtask

    task automatic model_sample(input logic [23:0] d, output logic [31:0] r);
        longint      x, acc, y;
        logic [15:0] y16;
        if (m_pend) begin
            m_ac   = m_sh;
            m_pend = 1'b0;
        end
        x = longint'($signed(d[23:8]));
        for (int s = 0; s < NS; s++) begin
            acc = 64'sd8192 + m_ac[s][0] * x + m_ac[s][1] * m_x1[s] + m_ac[s][2] * m_x2[s]
                  - m_ac[s][3] * m_y1[s] - m_ac[s][4] * m_y2[s];
            y = acc >>> 14;
            if (y > 32767) begin
                y = 32767;
                if (m_clip < 65535) m_clip++;
            end else if (y < -32768) begin
                y = -32768;
                if (m_clip < 65535) m_clip++;
            end
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_y2[s] = m_y1[s]; m_y1[s] = y;
            x = y;
        end
        y16 = x[15:0];
        r   = {8'h00, y16, 8'h00};
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("no_spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                check_eq("dac_data", dac_data, exp_q.pop_front());
                check_eq("latency", cyc - lat_q.pop_front(), LAT);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        lat_q.delete();
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic write_coef(input int s, input int sel, input logic [15:0] v);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_stage = 2'(s); coef_sel = 3'(sel); coef_wdata = v;
        m_sh[s][sel] = longint'($signed(v));
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic commit();
        @(posedge clk); #1;
        coef_commit = 1'b1;
        m_pend = 1'b1;
        @(posedge clk); #1;
        coef_commit = 1'b0;
    endtask

    // Drives one accepted sample; returns during cycle 1 of the computation.
    task automatic drive_sample(input logic [23:0] d, input bit use_const, input logic [31:0] c);
        logic [31:0] m;
        @(posedge clk); #1;
        model_sample(d, m);
        exp_q.push_back(use_const ? c : m);
        lat_q.push_back(cyc);
        sample_valid = 1'b1;
        adc_data     = d;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check_eq("busy_cycle1", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 2 * LAT) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("done_in_time", exp_q.size(), 32'd0);
        check_eq("busy_after", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_sample(input logic [23:0] d, input bit use_const, input logic [31:0] c);
        drive_sample(d, use_const, c);
        wait_done();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_dac", dac_data, 32'd0);
        check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("reset_busy", {31'b0, busy}, 32'd0);
        check_eq("reset_overrun", {31'b0, overrun}, 32'd0);
        check_eq("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;

        // Passthrough with reset coefficients.
        run_sample(24'h123456, 1'b1, 32'h00123400);

        // One-pole recursion on stage 0: y = x + 0.5*y1.
        apply_reset();
        write_coef(0, 0, 16'd16384);
        write_coef(0, 3, 16'hE000);
        commit();
        run_sample(24'h400000, 1'b1, 32'h00400000);
        run_sample(24'h000000, 1'b1, 32'h00200000);
        run_sample(24'h000000, 1'b1, 32'h00100000);
        run_sample(24'h000000, 1'b1, 32'h00080000);

        // Saturation in both directions.
        apply_reset();
        write_coef(0, 0, 16'd32767);
        commit();
        run_sample(24'h700000, 1'b1, 32'h007FFF00);
`ifdef AUDIO_BIQUAD_CLIP_COUNT_EN
        check_eq("clip_count_1", {16'h0, clip_count}, 32'd1);
`endif
        run_sample(24'h900000, 1'b1, 32'h00800000);
`ifdef AUDIO_BIQUAD_CLIP_COUNT_EN
        check_eq("clip_count_model", {16'h0, clip_count}, 32'(m_clip));
        @(posedge clk); #1 clip_clear = 1'b1;
        @(posedge clk); #1 clip_clear = 1'b0;
        check_eq("clip_cleared", {16'h0, clip_count}, 32'd0);
`endif

        // Overrun: second strobe 10 cycles into a sample is dropped.
        apply_reset();
        drive_sample(24'h123456, 1'b1, 32'h00123400);
        repeat (9) @(posedge clk);
        #1;
        check_eq("no_overrun_yet", {31'b0, overrun}, 32'd0);
        sample_valid = 1'b1;
        adc_data     = 24'h7FFFFF;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check_eq("overrun_pulse", {31'b0, overrun}, 32'd1);
        @(posedge clk); #1;
        check_eq("overrun_one_cycle", {31'b0, overrun}, 32'd0);
        wait_done();

        // Shadow write without commit has no effect; commit applies it.
        apply_reset();
        write_coef(2, 0, 16'd8192);
        run_sample(24'h200000, 1'b1, 32'h00200000);
        commit();
        run_sample(24'h200000, 1'b1, 32'h00100000);

        // Reset in cycle 12 of a sample aborts it.
        apply_reset();
        write_coef(1, 0, 16'd8192);
        commit();
        drive_sample(24'h123456, 1'b0, 32'h0);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        lat_q.delete();
        m_reset();
        #1;
        check_eq("abort_dac", dac_data, 32'd0);
        check_eq("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        check_eq("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        run_sample(24'h123456, 1'b1, 32'h00123400);

        // Random coefficients and samples against the model, including a
        // shadow write while busy that must not affect the sample in flight.
        apply_reset();
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < 5; c++) begin
                write_coef(s, c, 16'($urandom_range(0, 65535)));
            end
        end
        commit();
        for (int i = 0; i < 8; i++) begin
            drive_sample(24'($urandom_range(0, 24'hFFFFFF)), 1'b0, 32'h0);
            if (i == 3) begin
                write_coef(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 4)),
                           16'($urandom_range(0, 65535)));
                commit();
            end
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
